// File: rtl/vga_dac_pkg.sv
// rtl/vga_dac_pkg.sv - shared constants, FSM encoding and LUT helper for the VGA palette DAC
package vga_dac_pkg;

  localparam logic [1:0] PEL_MASK = 2'd0;
  localparam logic [1:0] RD_IDX   = 2'd1;
  localparam logic [1:0] WR_IDX   = 2'd2;
  localparam logic [1:0] DATA     = 2'd3;

  localparam logic [1:0] DAC_WRITE = 2'b00;
  localparam logic [1:0] DAC_READ  = 2'b11;

  localparam int VIDEO_LATENCY = 2;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_ACK     = 2'd2
  } cpu_state_e;

  // LUT entries are packed {red, green, blue}; sel 0/1/2 picks red/green/blue.
  function automatic logic [5:0] lut_component(input logic [17:0] entry, input logic [1:0] sel);
    case (sel)
      2'd0:    return entry[17:12];
      2'd1:    return entry[11:6];
      default: return entry[5:0];
    endcase
  endfunction

endpackage

// File: rtl/vga_dac_ram.sv
// rtl/vga_dac_ram.sv - 256x18 dual-port palette RAM, port A CPU read/write, port B video read
module vga_dac_ram (
  input  logic        clk,
  input  logic        we_a,
  input  logic [7:0]  addr_a,
  input  logic [17:0] wdata_a,
  output logic [17:0] rdata_a,
  input  logic [7:0]  addr_b,
  output logic [17:0] rdata_b
);

  logic [17:0] mem [256];

  // Both reads sample the array before this edge's write lands (read-before-write).
  always_ff @(posedge clk) begin
    if (we_a) mem[addr_a] <= wdata_a;
    rdata_a <= mem[addr_a];
    rdata_b <= mem[addr_b];
  end

endmodule

// File: rtl/vga_palette_dac.sv
// rtl/vga_palette_dac.sv - palette lookup and CPU DAC register block for the VGA pipeline
module vga_palette_dac
  import vga_dac_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] io_adr,
  input  logic [7:0] io_dat_i,
  output logic [7:0] io_dat_o,
  input  logic       io_we,
  input  logic       io_stb,
  output logic       io_ack,
  input  logic [7:0] color_i,
  input  logic       video_on_i,
  input  logic       hsync_i,
  output logic [5:0] vga_r,
  output logic [5:0] vga_g,
  output logic [5:0] vga_b,
  output logic       hsync_o,
  output logic       video_on_o
);

  cpu_state_e  state, state_nxt;
  logic [7:0]  pel_mask, wr_idx, rd_idx;
  logic [1:0]  wr_cnt, rd_cnt, rd_sel, dac_state;
  logic [5:0]  red_lat, grn_lat;
  logic        accept, is_data, ram_we;
  logic [7:0]  ram_addr_a;
  logic [17:0] ram_rdata_a, ram_rdata_b;
  logic [VIDEO_LATENCY-2:0] von_dly, hs_dly;

  assign is_data    = (io_adr == DATA);
  assign accept     = (state == ST_IDLE) && io_stb && !io_ack;
  assign ram_we     = accept && io_we && is_data && (wr_cnt == 2'd2);
  assign ram_addr_a = io_we ? wr_idx : rd_idx;

  vga_dac_ram u_ram (
    .clk     (clk),
    .we_a    (ram_we),
    .addr_a  (ram_addr_a),
    .wdata_a ({red_lat, grn_lat, io_dat_i[5:0]}),
    .rdata_a (ram_rdata_a),
    .addr_b  (color_i & pel_mask),
    .rdata_b (ram_rdata_b)
  );

  always_comb begin
    state_nxt = state;
    io_ack    = 1'b0;
    case (state)
      ST_IDLE:    if (accept) state_nxt = (is_data && !io_we) ? ST_RD_WAIT : ST_ACK;
      ST_RD_WAIT: state_nxt = ST_ACK;
      ST_ACK: begin
        io_ack    = 1'b1;
        state_nxt = ST_IDLE;
      end
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      pel_mask  <= 8'hFF;
      wr_idx    <= 8'd0;
      rd_idx    <= 8'd0;
      wr_cnt    <= 2'd0;
      rd_cnt    <= 2'd0;
      rd_sel    <= 2'd0;
      dac_state <= DAC_WRITE;
      red_lat   <= 6'd0;
      grn_lat   <= 6'd0;
      io_dat_o  <= 8'd0;
    end else begin
      state <= state_nxt;
      if (accept && io_we) begin
        case (io_adr)
          PEL_MASK: pel_mask <= io_dat_i;
          RD_IDX: begin
            rd_idx    <= io_dat_i;
            rd_cnt    <= 2'd0;
            dac_state <= DAC_READ;
          end
          WR_IDX: begin
            wr_idx    <= io_dat_i;
            wr_cnt    <= 2'd0;
            dac_state <= DAC_WRITE;
          end
          default: begin
            if (wr_cnt == 2'd0) red_lat <= io_dat_i[5:0];
            if (wr_cnt == 2'd1) grn_lat <= io_dat_i[5:0];
            if (wr_cnt == 2'd2) begin
              wr_idx <= wr_idx + 8'd1;
              wr_cnt <= 2'd0;
            end else begin
              wr_cnt <= wr_cnt + 2'd1;
            end
          end
        endcase
      end else if (accept) begin
        case (io_adr)
          PEL_MASK: io_dat_o <= pel_mask;
          RD_IDX:   io_dat_o <= {6'b0, dac_state};
          WR_IDX:   io_dat_o <= wr_idx;
          default: begin
            // RAM output arrives next cycle; remember which component was asked for.
            rd_sel <= rd_cnt;
            if (rd_cnt == 2'd2) begin
              rd_idx <= rd_idx + 8'd1;
              rd_cnt <= 2'd0;
            end else begin
              rd_cnt <= rd_cnt + 2'd1;
            end
          end
        endcase
      end
      if (state == ST_RD_WAIT) io_dat_o <= {2'b00, lut_component(ram_rdata_a, rd_sel)};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      von_dly    <= '0;
      hs_dly     <= '0;
      video_on_o <= 1'b0;
      hsync_o    <= 1'b0;
      vga_r      <= 6'd0;
      vga_g      <= 6'd0;
      vga_b      <= 6'd0;
    end else begin
      von_dly    <= video_on_i;
      hs_dly     <= hsync_i;
      video_on_o <= von_dly[VIDEO_LATENCY-2];
      hsync_o    <= hs_dly[VIDEO_LATENCY-2];
      vga_r      <= von_dly[VIDEO_LATENCY-2] ? ram_rdata_b[17:12] : 6'd0;
      vga_g      <= von_dly[VIDEO_LATENCY-2] ? ram_rdata_b[11:6]  : 6'd0;
      vga_b      <= von_dly[VIDEO_LATENCY-2] ? ram_rdata_b[5:0]   : 6'd0;
    end
  end

endmodule

// File: tb/tb_vga_palette_dac.sv
// tb/tb_vga_palette_dac.sv - scoreboard bench for the VGA palette DAC
module tb_vga_palette_dac;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] io_adr = 2'd0;
  logic [7:0] io_dat_i = 8'd0;
  logic [7:0] io_dat_o;
  logic       io_we = 1'b0;
  logic       io_stb = 1'b0;
  logic       io_ack;
  logic [7:0] color_i = 8'd0;
  logic       video_on_i = 1'b0;
  logic       hsync_i = 1'b0;
  logic [5:0] vga_r, vga_g, vga_b;
  logic       hsync_o, video_on_o;

  typedef struct {
    int          cyc;
    logic [19:0] v;
  } vexp_t;

  logic [7:0] cpu_q [$];
  vexp_t      vid_q [$];
  int         cyc = 0;
  int         n_pass = 0;
  int         n_total = 0;

  vga_palette_dac dut (
    .clk        (clk),
    .rst        (rst),
    .io_adr     (io_adr),
    .io_dat_i   (io_dat_i),
    .io_dat_o   (io_dat_o),
    .io_we      (io_we),
    .io_stb     (io_stb),
    .io_ack     (io_ack),
    .color_i    (color_i),
    .video_on_i (video_on_i),
    .hsync_i    (hsync_i),
    .vga_r      (vga_r),
    .vga_g      (vga_g),
    .vga_b      (vga_b),
    .hsync_o    (hsync_o),
    .video_on_o (video_on_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: CPU read data on each read ack, video outputs on their scheduled cycle.
  always @(negedge clk) begin
    if (io_ack && !io_we) begin
      if (cpu_q.size() == 0) check("cpu_unexpected_ack", 1, 0);
      else check("cpu_rdata", io_dat_o, cpu_q.pop_front());
    end
    if (vid_q.size() != 0 && vid_q[0].cyc == cyc) begin
      vexp_t e;
      e = vid_q.pop_front();
      check("video_out", {vga_r, vga_g, vga_b, hsync_o, video_on_o}, e.v);
    end
  end

  task automatic bus(input logic [1:0] adr, input logic we, input logic [7:0] d, input logic [7:0] exp);
    int n;
    int lat;
    lat = (!we && adr == 2'd3) ? 2 : 1;
    if (!we) cpu_q.push_back(exp);
    @(posedge clk); #1;
    io_adr = adr; io_we = we; io_dat_i = d; io_stb = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!io_ack && n < 8);
    check("ack_latency", io_ack ? n : 99, lat);
    @(negedge clk); #1;
    io_stb = 1'b0; io_we = 1'b0;
  endtask

  task automatic wr(input logic [1:0] adr, input logic [7:0] d);
    bus(adr, 1'b1, d, 8'h00);
  endtask

  task automatic rd(input logic [1:0] adr, input logic [7:0] exp);
    bus(adr, 1'b0, 8'h00, exp);
  endtask

  task automatic pixel(input logic [7:0] c, input logic von, input logic hs, input logic [17:0] rgb);
    vexp_t e;
    @(posedge clk); #1;
    color_i = c; video_on_i = von; hsync_i = hs;
    e.cyc = cyc + 2;
    e.v = {von ? rgb : 18'd0, hs, von};
    vid_q.push_back(e);
  endtask

  task automatic vid_flush();
    @(posedge clk); #1;
    color_i = 8'd0; video_on_i = 1'b0; hsync_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("reset_video", {vga_r, vga_g, vga_b, hsync_o, video_on_o}, 20'd0);
    check("reset_ack", io_ack, 0);
    check("reset_dat_o", io_dat_o, 0);
    rst = 1'b0;

    rd(2'd0, 8'hFF);
    rd(2'd1, 8'h00);
    rd(2'd2, 8'h00);

    wr(2'd2, 8'h10);
    wr(2'd3, 8'h3F); wr(2'd3, 8'h15); wr(2'd3, 8'h2A);
    wr(2'd3, 8'h01); wr(2'd3, 8'h02); wr(2'd3, 8'h03);
    pixel(8'h10, 1'b1, 1'b1, {6'h3F, 6'h15, 6'h2A});
    pixel(8'h10, 1'b1, 1'b0, {6'h3F, 6'h15, 6'h2A});
    pixel(8'h11, 1'b1, 1'b1, {6'h01, 6'h02, 6'h03});
    vid_flush();

    wr(2'd2, 8'hFF);
    wr(2'd3, 8'h0A); wr(2'd3, 8'h0B); wr(2'd3, 8'h0C);
    wr(2'd3, 8'h0D); wr(2'd3, 8'h0E); wr(2'd3, 8'h0F);
    rd(2'd2, 8'h01);
    pixel(8'hFF, 1'b1, 1'b0, {6'h0A, 6'h0B, 6'h0C});
    pixel(8'h00, 1'b1, 1'b0, {6'h0D, 6'h0E, 6'h0F});
    vid_flush();

    wr(2'd1, 8'h10);
    rd(2'd3, 8'h3F); rd(2'd3, 8'h15); rd(2'd3, 8'h2A);
    rd(2'd1, 8'h03);
    rd(2'd3, 8'h01);

    wr(2'd0, 8'h0F);
    rd(2'd0, 8'h0F);
    pixel(8'hF0, 1'b1, 1'b1, {6'h0D, 6'h0E, 6'h0F});
    pixel(8'hF0, 1'b0, 1'b0, 18'd0);
    pixel(8'h10, 1'b0, 1'b1, 18'd0);
    vid_flush();
    wr(2'd0, 8'hFF);

    wr(2'd3, 8'h21); wr(2'd3, 8'h22);
    wr(2'd2, 8'h20);
    wr(2'd3, 8'h05); wr(2'd3, 8'h06); wr(2'd3, 8'h07);
    rd(2'd2, 8'h21);
    rd(2'd1, 8'h00);
    pixel(8'h20, 1'b1, 1'b0, {6'h05, 6'h06, 6'h07});
    vid_flush();

    wr(2'd2, 8'h30);
    wr(2'd3, 8'h31); wr(2'd3, 8'h32);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(2'd2, 8'h00);
    rd(2'd1, 8'h00);
    rd(2'd0, 8'hFF);
    wr(2'd3, 8'h08); wr(2'd3, 8'h09); wr(2'd3, 8'h0A);
    pixel(8'h00, 1'b1, 1'b1, {6'h08, 6'h09, 6'h0A});
    vid_flush();
    rd(2'd2, 8'h01);

    repeat (4) @(posedge clk);
    #1;
    check("cpu_queue_drained", cpu_q.size(), 0);
    check("video_queue_drained", vid_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
